// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with double-buffered CPU writes.
// Define SEG7_LZB_EN to enable leading-zero blanking of digits 3..1.
module seg7_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 1000,
  parameter int unsigned GAP_CYCLES  = 8
) (
  input  logic        system1000,
  input  logic        system1000_rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  input  logic [3:0]  wr_blank,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DRV_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit GAP_EN = (GAP_CYCLES > 0);

  typedef enum logic {DARK, DRIVE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   act_dig_q, act_dig_d, sh_dig_q, sh_dig_d;
  logic [3:0]    act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
  logic [3:0]    act_blk_q, act_blk_d, sh_blk_q, sh_blk_d;
  logic          pending_q, pending_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          ft_q, ft_d;
  logic          accept, boundary, lzb;
  logic [3:0]    cur;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    hex7 = 7'h7F;
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    boundary = 1'b0;
    unique case (state_q)
      DARK: begin
        if (!GAP_EN || cnt_q == GAP_LAST) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == DRV_LAST) begin
          state_d  = GAP_EN ? DARK : DRIVE;
          cnt_d    = '0;
          idx_d    = idx_q + 2'd1;
          boundary = (idx_q == 2'd3);
        end
      end
      default: ;
    endcase
  end

  // Commit only ever sees a write accepted in an earlier cycle: accept needs !pending.
  assign accept = wr_valid && !pending_q;

  always_comb begin
    pending_d = pending_q;
    sh_dig_d  = sh_dig_q;
    sh_dp_d   = sh_dp_q;
    sh_blk_d  = sh_blk_q;
    act_dig_d = act_dig_q;
    act_dp_d  = act_dp_q;
    act_blk_d = act_blk_q;
    if (boundary && pending_q) begin
      act_dig_d = sh_dig_q;
      act_dp_d  = sh_dp_q;
      act_blk_d = sh_blk_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      sh_dig_d  = wr_data;
      sh_dp_d   = wr_dp;
      sh_blk_d  = wr_blank;
      pending_d = 1'b1;
    end
  end

  // Outputs are registered from next-state values so they move with state/idx.
  always_comb begin
    an_d  = 4'hF;
    seg_d = 8'hFF;
    ft_d  = 1'b0;
    cur   = act_dig_d[{idx_d, 2'b00} +: 4];
    lzb   = 1'b0;
`ifdef SEG7_LZB_EN
    case (idx_d)
      2'd3:    lzb = (act_dig_d[15:12] == 4'h0);
      2'd2:    lzb = (act_dig_d[15:8] == 8'h00);
      2'd1:    lzb = (act_dig_d[15:4] == 12'h000);
      default: lzb = 1'b0;
    endcase
`endif
    if (state_d == DRIVE) begin
      an_d = ~(4'b0001 << idx_d);
      if (act_blk_d[idx_d])
        seg_d = 8'hFF;
      else if (lzb)
        seg_d = {~act_dp_d[idx_d], 7'h7F};
      else
        seg_d = {~act_dp_d[idx_d], hex7(cur)};
      ft_d = (idx_d == 2'd3) && (cnt_d == DRV_LAST);
    end
  end

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      state_q   <= DARK;
      cnt_q     <= '0;
      idx_q     <= '0;
      act_dig_q <= '0;
      act_dp_q  <= '0;
      act_blk_q <= '0;
      sh_dig_q  <= '0;
      sh_dp_q   <= '0;
      sh_blk_q  <= '0;
      pending_q <= 1'b0;
      seg_q     <= '1;
      an_q      <= '1;
      ft_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      act_dig_q <= act_dig_d;
      act_dp_q  <= act_dp_d;
      act_blk_q <= act_blk_d;
      sh_dig_q  <= sh_dig_d;
      sh_dp_q   <= sh_dp_d;
      sh_blk_q  <= sh_blk_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      ft_q      <= ft_d;
    end
  end

  assign wr_ready   = ~pending_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with REFRESH_DIV=4, GAP_CYCLES=1 (20-cycle frames).
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic [3:0]  wr_blank;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  logic [12:0] exp_q[$];
  logic [12:0] obs_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  seg7_scan_ctrl #(.REFRESH_DIV(4), .GAP_CYCLES(1)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .wr_dp          (wr_dp),
    .wr_blank       (wr_blank),
    .seg            (seg),
    .an             (an),
    .frame_tick     (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [6:0] ref_hex(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // One full frame, position 0 = dark slot before digit 0, position 19 = frame_tick.
  task automatic push_expected(input logic [15:0] dig, input logic [3:0] dp, input logic [3:0] blk);
    for (int pos = 0; pos < 20; pos++) begin
      int d;
      logic [3:0] a;
      logic [7:0] s;
      logic       lz;
      logic [15:0] hi;
      d  = pos / 5;
      a  = 4'hF;
      s  = 8'hFF;
      hi = dig >> (4 * d);
      lz = 1'b0;
`ifdef SEG7_LZB_EN
      lz = (d > 0) && (hi == 16'h0000);
`endif
      if (pos % 5 != 0) begin
        a = ~(4'b0001 << d);
        if (blk[d])      s = 8'hFF;
        else if (lz)     s = {~dp[d], 7'h7F};
        else             s = {~dp[d], ref_hex(hi[3:0])};
      end
      exp_q.push_back({(pos == 19), a, s});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_obs();
    obs_q.push_back({frame_tick, an, seg});
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      sample_obs();
    end
  endtask

  task automatic sync_frame();
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = frame_tick;
    end
    if (!seen) begin
      n_err++;
      $display("FAIL sync_frame: frame_tick not seen within 40 cycles");
    end
  endtask

  task automatic do_write(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] blk);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_dp    = dp;
    wr_blank = blk;
    for (int i = 0; i < 60 && !wr_ready; i++) tick();
    if (!wr_ready) begin
      n_err++;
      $display("FAIL do_write: wr_ready stayed 0 for 60 cycles");
    end
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_dp = '0; wr_blank = '0;
    repeat (3) tick();
    rst = 1'b0;
    do_write(16'hFFFF, 4'hF, 4'h0);
    repeat (5) tick();
    n_vec++;
    if (an !== 4'hD) begin n_err++; $display("FAIL reset_pre_an: got %h want D", an); end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({an, seg, wr_ready, frame_tick} !== {4'hF, 8'hFF, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_async: an=%h seg=%h rdy=%b ft=%b want F FF 1 0", an, seg, wr_ready, frame_tick);
    end
    tick(); tick();
    rst = 1'b0;
    push_expected(16'h0000, 4'h0, 4'h0);
    sample_obs();
    capture(19);
    for (int i = 0; i < 20; i++) begin
      logic [12:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL reset_frame pos %0d: got %h want %h", i, o, e); end
    end
    n_vec++;
    if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", wr_ready); end
  endtask

  task automatic test_write_scan();
    tick(); tick();
    do_write(16'h1234, 4'b0100, 4'h0);
    n_vec++;
    if (wr_ready !== 1'b0) begin n_err++; $display("FAIL write_ready_fall: got %b want 0", wr_ready); end
    sync_frame();
    n_vec++;
    if (wr_ready !== 1'b0) begin n_err++; $display("FAIL write_ready_boundary: got %b want 0", wr_ready); end
    tick();
    n_vec++;
    if (wr_ready !== 1'b1) begin n_err++; $display("FAIL write_ready_rise: got %b want 1", wr_ready); end
    push_expected(16'h1234, 4'b0100, 4'h0);
    sample_obs();
    capture(19);
    for (int i = 0; i < 20; i++) begin
      logic [12:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL write_scan pos %0d: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_back_pressure();
    int waited;
    tick();
    wr_valid = 1'b1; wr_data = 16'h5678; wr_dp = 4'h0; wr_blank = 4'h0;
    tick();
    wr_data = 16'hFFFF;
    n_vec++;
    if (wr_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_fall: got %b want 0", wr_ready); end
    waited = 0;
    while (!wr_ready && waited < 45) begin tick(); waited++; end
    n_vec++;
    if (waited !== 19) begin n_err++; $display("FAIL bp_wait: got %0d cycles want 19", waited); end
    push_expected(16'h5678, 4'h0, 4'h0);
    sample_obs();
    tick();
    wr_valid = 1'b0;
    sample_obs();
    n_vec++;
    if (wr_ready !== 1'b0) begin n_err++; $display("FAIL bp_second_accept: got rdy %b want 0", wr_ready); end
    capture(18);
    push_expected(16'hFFFF, 4'h0, 4'h0);
    capture(20);
    for (int i = 0; i < 40; i++) begin
      logic [12:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL back_pressure pos %0d: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_back_to_back_boundary();
    push_expected(16'hFFFF, 4'h0, 4'h0);
    capture(19);
    tick();
    sample_obs();
    wr_valid = 1'b1; wr_data = 16'h9876; wr_dp = 4'h0; wr_blank = 4'h0;
    tick();
    wr_valid = 1'b0;
    n_vec++;
    if (wr_ready !== 1'b0) begin n_err++; $display("FAIL race_accept: got rdy %b want 0", wr_ready); end
    push_expected(16'hFFFF, 4'h0, 4'h0);
    sample_obs();
    capture(19);
    push_expected(16'h9876, 4'h0, 4'h0);
    capture(20);
    for (int i = 0; i < 60; i++) begin
      logic [12:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL boundary_race pos %0d: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_blank_mask();
    tick();
    do_write(16'h8888, 4'hF, 4'b1010);
    sync_frame();
    push_expected(16'h8888, 4'hF, 4'b1010);
    capture(20);
    for (int i = 0; i < 20; i++) begin
      logic [12:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL blank_mask pos %0d: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_lzb();
    tick();
    do_write(16'h0050, 4'h0, 4'h0);
    sync_frame();
    push_expected(16'h0050, 4'h0, 4'h0);
    capture(20);
    tick();
    do_write(16'h0005, 4'b1000, 4'h0);
    sync_frame();
    push_expected(16'h0005, 4'b1000, 4'h0);
    capture(20);
    for (int i = 0; i < 40; i++) begin
      logic [12:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL lzb pos %0d: got %h want %h", i, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_write_scan();
    test_back_pressure();
    test_back_to_back_boundary();
    test_blank_mask();
    test_lzb();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for the board's 4-digit, 8-segment LED display, which is driven by the 13-bit `{dp_flag, an[3:0], seg[7:0]}` output bundle of the machine top level. It holds four hex digits, decimal-point and blank masks written by the CPU through a valid/ready port, and sequences the anode strobes with a dark interval between digits to suppress ghosting. CPU updates are double-buffered and committed only at frame boundaries, so the display never tears mid-frame.

## Interface
- `REFRESH_DIV`, 1000: cycles each digit is driven; must be ≥1.
- `GAP_CYCLES`, 8: dark cycles before each digit (all anodes off); 0 allowed.
- `system1000`  in  1  clock.
- `system1000_rst`  in  1  reset. Asynchronous, active-high.
- `wr_valid`  in  1  CPU write request.
- `wr_ready`  out  1  controller can accept a write.
- `wr_data`  in  16  hex digits; `[3:0]` is digit 0 (rightmost).
- `wr_dp`  in  4  decimal point per digit, 1 = lit.
- `wr_blank`  in  4  per-digit force-blank, 1 = dark.
- `seg`  out  8  active-low `{dp,g,f,e,d,c,b,a}`.
- `an`  out  4  active-low anode select; `an[i]` is digit i.
- `frame_tick`  out  1  one-cycle pulse at each frame wrap.

## Operation
- **State registers:**
  - FSM `DARK` / `DRIVE`.
  - Cycle counter `cnt`.
  - Digit index `idx` (2 bits).
  - Active set (digits, dp, blank).
  - Shadow set.
  - `pending` flag.
- **`DARK`:** `an` = 4'hF, `seg` = 8'hFF.
  - Lasts `GAP_CYCLES` cycles, then goes to `DRIVE`.
  - If `GAP_CYCLES` = 0, `DARK` is skipped entirely.
- **`DRIVE`:** `an` = ~(1<<idx).
  - `seg[6:0]` = hex decode of active digit idx; `seg[7]` = ~dp[idx].
  - If blank[idx] = 1, `seg` = 8'hFF but `an` is still driven.
  - Lasts `REFRESH_DIV` cycles.
  - Exit: idx ← idx+1 (wraps 3→0), then go to `DARK`.
- **Decode** (active-low gfedcba):
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78
  - 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E
- **Write handshake:**
  - `wr_ready` = ~pending.
  - A write is accepted when `wr_valid`&&`wr_ready`: it loads the shadow set and sets `pending`.
  - `wr_data` must be held stable only in the accept cycle.
- **Commit:** happens on the cycle `DRIVE` exits with idx = 3 (frame boundary).
  - If `pending`: shadow → active, `pending` cleared.
  - `frame_tick` pulses in this same cycle regardless of `pending`.
- **Simultaneous accept and boundary:** the write accepted in the boundary cycle is not committed in that boundary (`pending` was 0). It commits at the next frame boundary.
- **Reset mid-operation:** everything returns to reset values immediately; the shadow set is discarded.

## Timing
- **Reset values:**
  - `an` = 4'hF, `seg` = 8'hFF, `frame_tick` = 0, `wr_ready` = 1.
  - State `DARK`, idx = 0, cnt = 0, `pending` = 0.
  - Active and shadow digits/dp/blank = 0.
- `an`, `seg` and `frame_tick` are registered and change on the same edge as the state/idx change.
- Frame length = 4×(`GAP_CYCLES`+`REFRESH_DIV`) cycles.
- **First `DRIVE` of digit 0:** `an` = 4'hE from cycle `GAP_CYCLES` after reset release, where cycle 0 is the first edge.
- **Write latency:**
  - `wr_ready` falls the cycle after accept.
  - New values appear at the first `DRIVE` of digit 0 after the next frame boundary.
  - `wr_ready` rises the cycle after commit.
- **Counter:** sized to max(`REFRESH_DIV`,`GAP_CYCLES`); counts 0..N-1 and clears on each state change.

## Configuration
- **`SEG7_LZB_EN` defined:** leading-zero blanking.
  - Digit i (i = 3..1) is dark if its value is 0 and all higher digits are 0.
  - Its dp is still shown if set.
  - Digit 0 is never zero-blanked.
  - Applied after the explicit blank mask (OR of both).
- **Undefined:** all digits are shown unless explicitly blanked.

## Test plan
Use `REFRESH_DIV`=4, `GAP_CYCLES`=1 throughout.
- **Reset:** assert reset mid-`DRIVE` → `an`=F, `seg`=FF, `wr_ready`=1 next sample. After release, `an`=E with `seg`=0x40 from cycle 1 to cycle 4; `frame_tick` at cycle 19.
- **Write and scan:** write `wr_data`=0x1234, `wr_dp`=4'b0100 → `wr_ready`=0 until after the boundary. The next frame scans `an` E,D,B,7 with `seg` 0x19, 0x30, 0x24 (dp bit 0 → 0x24 & 0x7F = 0x24), 0x79.
- **Back-pressure:** `wr_valid` is held with a second value 0xFFFF while `pending` → not accepted until `wr_ready` returns. It then commits one frame later; all digits show 0x0E.
- **Boundary race:** accept a write in the same cycle as `frame_tick` → the old digits persist for one more full frame (20 cycles).
- **Blank mask:** `wr_blank`=4'b1010 → digits 1 and 3 show `seg`=FF while `an`=D/7 is still strobed.
- **`SEG7_LZB_EN` build:** `wr_data`=0x0050 → digits 3 and 2 dark, digit 1 = 0x12, digit 0 = 0x40. Without the macro, digits 3 and 2 show 0x40.
